// File: rtl/trem_lfo_if.sv
// Sample-stream and control bundle for the tremolo block.
// The master drives control and input samples; the slave returns output samples.
interface trem_lfo_if #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 8
);
  logic                     en;
  logic [3:0]               options;
  logic                     shape;
  logic [GAIN_W-1:0]        depth;
  logic                     x_valid;
  logic signed [DATA_W-1:0] x;
  logic                     y_valid;
  logic signed [DATA_W-1:0] y;

  modport master (
    output en, options, shape, depth, x_valid, x,
    input  y_valid, y
  );

  modport slave (
    input  en, options, shape, depth, x_valid, x,
    output y_valid, y
  );
endinterface

// File: rtl/trem_lfo.sv
// Tremolo: amplitude-modulates a signed sample stream with an internal LFO.
// A phase accumulator advances once per accepted sample, so the LFO rate is
// tied to the sample rate. The path is a fixed two-stage pipeline:
// stage 1 captures the sample and its gain, and stage 2 scales the sample.
// PHASE_W-1 must be >= GAIN_W so the triangle slice fits below the phase MSB.
module trem_lfo #(
  parameter int DATA_W    = 32,
  parameter int PHASE_W   = 16,
  parameter int GAIN_W    = 8,
  parameter int RATE_BASE = 1
) (
  input  logic     clk_48,
  input  logic     rst,
  trem_lfo_if.slave bus
);

  localparam int                 PROD_W   = DATA_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0]  MAX      = '1;
  localparam logic [PHASE_W-1:0] RATE_INC = PHASE_W'(RATE_BASE);

  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic                     v1_q, v1_d;
  logic signed [DATA_W-1:0] x1_q, x1_d;
  logic [GAIN_W-1:0]        gain1_q, gain1_d;
  logic                     byp1_q, byp1_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     y_valid_q, y_valid_d;

  logic [GAIN_W-1:0]        tri_t;
  logic [GAIN_W-1:0]        lfo;
  logic [2*GAIN_W-1:0]      depth_ext;
  logic [2*GAIN_W-1:0]      inv_ext;
  logic [GAIN_W-1:0]        gain_c;
  logic [PHASE_W-1:0]       inc;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] g_ext;

  // LFO shape and gain, taken from the phase before this sample's increment.
  always_comb begin
    tri_t = phase_q[PHASE_W-2 -: GAIN_W];
    if (bus.shape) begin
      lfo = phase_q[PHASE_W-1] ? '0 : MAX;
    end else begin
      lfo = phase_q[PHASE_W-1] ? ~tri_t : tri_t;
    end
    depth_ext = {{GAIN_W{1'b0}}, bus.depth};
    inv_ext   = {{GAIN_W{1'b0}}, MAX - lfo};
    // Depth scales how far the gain dips below MAX; the top half of the
    // product keeps the result in 1..MAX.
    gain_c    = MAX - GAIN_W'((depth_ext * inv_ext) >> GAIN_W);
  end

  // Phase step: advance only on a one-hot rate select; bypass parks it at 0.
  always_comb begin
    // NOTE: every variable in a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    inc     = '0;
    phase_d = phase_q;
    for (int k = 0; k < 4; k++) begin
      if (bus.options[k]) inc = RATE_INC << k;
    end
    if (!bus.en) begin
      phase_d = '0;
    end else if (bus.x_valid && $onehot(bus.options)) begin
      phase_d = phase_q + inc;
    end
  end

  // Stage-1 capture: sample, gain and bypass flag travel together.
  always_comb begin
    v1_d    = bus.x_valid;
    x1_d    = x1_q;
    gain1_d = gain1_q;
    byp1_d  = byp1_q;
    if (bus.x_valid) begin
      x1_d    = bus.x;
      gain1_d = gain_c;
      byp1_d  = !bus.en;
    end
  end

  // Stage-2 scale: floor-rounded signed product; y holds between samples.
  always_comb begin
    x_ext     = PROD_W'(x1_q);
    g_ext     = PROD_W'($signed({1'b0, gain1_q}));
    y_valid_d = v1_q;
    y_d       = y_q;
    if (v1_q) begin
      y_d = byp1_q ? x1_q : DATA_W'((x_ext * g_ext) >>> GAIN_W);
    end
  end

  // Pipeline and phase registers with synchronous reset; a reset drops any
  // sample in flight.
  always_ff @(posedge clk_48) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // values, so register order inside this block does not matter.
    if (rst) begin
      phase_q   <= '0;
      v1_q      <= 1'b0;
      x1_q      <= '0;
      gain1_q   <= '0;
      byp1_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      v1_q      <= v1_d;
      x1_q      <= x1_d;
      gain1_q   <= gain1_d;
      byp1_q    <= byp1_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_trem_lfo.sv
// Directed bench for trem_lfo: reset, gain arithmetic, square and triangle
// LFO boundaries, bypass latency, frozen-phase rate selects, mid-burst reset.
module tb_trem_lfo;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   nv;
  bit [15:0] pat;

  trem_lfo_if #(.DATA_W(32), .GAIN_W(8)) bus ();

  trem_lfo #(
    .DATA_W   (32),
    .PHASE_W  (16),
    .GAIN_W   (8),
    .RATE_BASE(1)
  ) dut (
    .clk_48(clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sample from an idle pipe (when idle=1): verifies the 2-cycle latency,
  // the single-cycle y_valid pulse and that y holds afterwards.
  task automatic send(input logic signed [31:0] xv, input logic signed [31:0] exp,
                      input string tag, input bit idle);
    bus.x       = xv;
    bus.x_valid = 1'b1;
    @(negedge clk);
    bus.x_valid = 1'b0;
    if (idle) check({tag, "_vld_n1"}, 64'(bus.y_valid), 64'sd0);
    @(negedge clk);
    check({tag, "_vld_n2"}, 64'(bus.y_valid), 64'sd1);
    check({tag, "_y"}, 64'(bus.y), 64'(exp));
    @(negedge clk);
    check({tag, "_vld_n3"}, 64'(bus.y_valid), 64'sd0);
    check({tag, "_hold"}, 64'(bus.y), 64'(exp));
  endtask

  // n back-to-back samples with the current x, then drain; counts y_valid.
  task automatic stream(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n + 2; i++) begin
      bus.x_valid = (i < n);
      @(negedge clk);
      if (bus.y_valid) cnt++;
    end
    bus.x_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.options = 4'b0000;
    bus.shape   = 1'b0;
    bus.depth   = 8'd255;
    bus.x_valid = 1'b1;
    bus.x       = 32'sd1234;

    // 1: reset held 3 cycles with x_valid high, then one cycle after release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_vld", 64'(bus.y_valid), 64'sd0);
      check("rst_y", 64'(bus.y), 64'sd0);
    end
    rst         = 1'b0;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check("rst_rel_vld", 64'(bus.y_valid), 64'sd0);
    check("rst_rel_y", 64'(bus.y), 64'sd0);

    // 2: triangle at phase 0 (options frozen at 0)
    send(32'sd1000, 32'sd3, "tri_d255", 1'b1);
    bus.depth = 8'd0;
    send(32'sd1000, 32'sd996, "tri_d0", 1'b1);
    send(-32'sd1000, -32'sd997, "tri_d0_neg", 1'b1);

    // 3: square, rate 1, across the phase MSB
    bus.shape   = 1'b1;
    bus.options = 4'b0001;
    bus.depth   = 8'd255;
    send(32'sd1000, 32'sd996, "sq_ph0", 1'b1);
    stream(32766, nv);
    check("sq_stream_cnt", 64'(nv), 64'sd32766);
    send(32'sd1000, 32'sd996, "sq_ph32767", 1'b1);
    send(32'sd1000, 32'sd3, "sq_ph32768", 1'b1);

    // 4: triangle, rate 8, peak and wrap
    pulse_reset();
    bus.shape   = 1'b0;
    bus.options = 4'b1000;
    bus.x       = 32'sd25600;
    send(32'sd25600, 32'sd100, "tri_s0", 1'b1);
    stream(4095, nv);
    send(32'sd25600, 32'sd25500, "tri_s4096", 1'b1);
    stream(4095, nv);
    send(32'sd25600, 32'sd100, "tri_s8192", 1'b1);
    stream(2047, nv);
    send(32'sd25600, 32'sd12900, "tri_quarter", 1'b1);

    // 5: bypass, y_valid mirrors x_valid two cycles later, y = x
    bus.en = 1'b0;
    pat    = 16'b1011_0011_1110_0101;
    for (int j = 0; j < 18; j++) begin
      if (j >= 2) begin
        check("byp_vld", 64'(bus.y_valid), 64'(pat[j-2]));
        if (pat[j-2]) check("byp_y", 64'(bus.y), 64'(-5 - (j - 2)));
      end else begin
        check("byp_vld_pre", 64'(bus.y_valid), 64'sd0);
      end
      bus.x_valid = (j < 16) ? pat[j] : 1'b0;
      bus.x       = 32'(-5 - j);
      @(negedge clk);
    end
    bus.en      = 1'b1;
    bus.options = 4'b0001;
    send(32'sd1000, 32'sd3, "reen_ph0", 1'b1);

    // 6: multi-hot and zero options freeze the phase just below a step
    bus.x       = 32'sd25600;
    bus.options = 4'b1000;
    stream(2063, nv);
    bus.options = 4'b0001;
    stream(6, nv);
    bus.options = 4'b0011;
    stream(100, nv);
    check("multihot_cnt", 64'(nv), 64'sd100);
    send(32'sd25600, 32'sd12900, "multihot_frozen", 1'b1);
    bus.options = 4'b0000;
    send(32'sd25600, 32'sd12900, "zero_frozen", 1'b1);
    bus.options = 4'b0001;
    send(32'sd25600, 32'sd12900, "resume_ph16511", 1'b1);
    send(32'sd25600, 32'sd13000, "resume_ph16512", 1'b1);

    // mid-burst reset drops in-flight samples
    bus.x_valid = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_vld1", 64'(bus.y_valid), 64'sd0);
    check("midrst_y1", 64'(bus.y), 64'sd0);
    @(negedge clk);
    check("midrst_vld2", 64'(bus.y_valid), 64'sd0);
    rst         = 1'b0;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check("midrst_vld3", 64'(bus.y_valid), 64'sd0);
    @(negedge clk);
    check("midrst_vld4", 64'(bus.y_valid), 64'sd0);
    check("midrst_y4", 64'(bus.y), 64'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
